// File: rtl/cache_ctrl_fsm_if.sv
// Bundle of CPU request, cache-array and memory-bus signals around
// the cache controller. slave = controller side, master = its surroundings.
interface cache_ctrl_fsm_if #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 6
);
    localparam int TAG_WIDTH  = 30 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int BLOCK_BITS = 32 << OFFSET_WIDTH;

    logic                    cpu_req;
    logic                    cpu_we;
    logic [31:0]             cpu_addr;
    logic                    cpu_ready;

    logic                    c_enable;
    logic                    c_cmp;
    logic                    c_write;
    logic                    c_valid_in;
    logic [TAG_WIDTH-1:0]    c_tag;
    logic [INDEX_WIDTH-1:0]  c_index;
    logic [OFFSET_WIDTH-1:0] c_word_sel;
    logic [BLOCK_BITS-1:0]   c_block_in;
    logic                    c_hit;
    logic                    c_dirty;
    logic [TAG_WIDTH-1:0]    c_tag_out;
    logic [BLOCK_BITS-1:0]   c_data_wb;

    logic                    mem_req;
    logic                    mem_we;
    logic [31:0]             mem_addr;
    logic [BLOCK_BITS-1:0]   mem_wdata;
    logic [BLOCK_BITS-1:0]   mem_rdata;
    logic                    mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr,
        output cpu_ready,
        output c_enable, c_cmp, c_write, c_valid_in,
        output c_tag, c_index, c_word_sel, c_block_in,
        input  c_hit, c_dirty, c_tag_out, c_data_wb,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr,
        input  cpu_ready,
        input  c_enable, c_cmp, c_write, c_valid_in,
        input  c_tag, c_index, c_word_sel, c_block_in,
        output c_hit, c_dirty, c_tag_out, c_data_wb,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 2-way set-associative cache array.
// Optional CACHE_PERF_CNT_EN adds saturating hit/miss counters.
module cache_ctrl_fsm #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 6
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]     perf_hit_cnt,
    output logic [31:0]     perf_miss_cnt,
`endif
    cache_ctrl_fsm_if.slave bus
);
    localparam int TAG_WIDTH  = 30 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int BLOCK_BITS = 32 << OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE, COMPARE, PROBE, WB, ALLOC, REFILL
    } state_t;

    state_t                  state, state_nxt;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [OFFSET_WIDTH-1:0] word_q;
    logic                    we_q;
    logic [TAG_WIDTH-1:0]    vtag_q;
    logic [BLOCK_BITS-1:0]   wb_buf;
    logic [BLOCK_BITS-1:0]   rf_buf;
    logic                    unused_ok;

    assign unused_ok = ^bus.cpu_addr[1:0];

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // latch the request address split and direction on acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q   <= '0;
            index_q <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE && bus.cpu_req) begin
            word_q  <= bus.cpu_addr[2 +: OFFSET_WIDTH];
            index_q <= bus.cpu_addr[2+OFFSET_WIDTH +: INDEX_WIDTH];
            tag_q   <= bus.cpu_addr[31 -: TAG_WIDTH];
            we_q    <= bus.cpu_we;
        end
    end

    // victim and refill buffers; contents only matter in WB / REFILL
    always_ff @(posedge clk) begin
        if (state == PROBE) begin
            vtag_q <= bus.c_tag_out;
            wb_buf <= bus.c_data_wb;
        end
        if (state == ALLOC && bus.mem_ack) rf_buf <= bus.mem_rdata;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.cpu_req) state_nxt = COMPARE;
            COMPARE: state_nxt = bus.c_hit ? IDLE : PROBE;
            PROBE:   state_nxt = bus.c_dirty ? WB : ALLOC;
            WB:      if (bus.mem_ack) state_nxt = ALLOC;
            ALLOC:   if (bus.mem_ack) state_nxt = REFILL;
            REFILL:  state_nxt = COMPARE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.c_tag      = tag_q;
    assign bus.c_index    = index_q;
    assign bus.c_word_sel = word_q;

    // control outputs decoded from state
    always_comb begin
        bus.cpu_ready  = 1'b0;
        bus.c_enable   = 1'b0;
        bus.c_cmp      = 1'b0;
        bus.c_write    = 1'b0;
        bus.c_valid_in = 1'b0;
        bus.c_block_in = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state)
            COMPARE: begin
                bus.c_enable   = 1'b1;
                bus.c_cmp      = 1'b1;
                bus.c_write    = we_q;
                bus.c_valid_in = 1'b1;
                bus.cpu_ready  = bus.c_hit;
            end
            PROBE: bus.c_enable = 1'b1;
            WB: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {vtag_q, index_q,
                                 {(OFFSET_WIDTH+2){1'b0}}};
                bus.mem_wdata = wb_buf;
            end
            ALLOC: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag_q, index_q,
                                {(OFFSET_WIDTH+2){1'b0}}};
            end
            REFILL: begin
                bus.c_enable   = 1'b1;
                bus.c_write    = 1'b1;
                bus.c_valid_in = 1'b1;
                bus.c_block_in = rf_buf;
            end
            default: ;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic retry_q;

    // count first-try hits and all misses, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            retry_q       <= 1'b0;
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else begin
            retry_q <= (state == REFILL);
            if (state == COMPARE && bus.c_hit && !retry_q
                && perf_hit_cnt != 32'hFFFF_FFFF)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (state == COMPARE && !bus.c_hit
                && perf_miss_cnt != 32'hFFFF_FFFF)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: behavioural array + memory around the DUT,
// checked against a set/LRU/word-memory reference model.
module tb_cache_ctrl_fsm;
    localparam int OFF = 3;
    localparam int IDX = 6;
    localparam int TAG = 30 - OFF - IDX;
    localparam int BB  = 32 << OFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_fsm_if #(.OFFSET_WIDTH(OFF), .INDEX_WIDTH(IDX)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    cache_ctrl_fsm #(.OFFSET_WIDTH(OFF), .INDEX_WIDTH(IDX)) dut (
        .clk(clk),
        .rst(rst),
`ifdef CACHE_PERF_CNT_EN
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt),
`endif
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit [BB-1:0] blk_init(input bit [31:0] ba);
        bit [BB-1:0] r;
        for (int w = 0; w < (1 << OFF); w++)
            r[w*32 +: 32] = init_word(ba + 32'(w * 4));
        return r;
    endfunction

    // behavioural cache array (2 ways, LRU)
    bit            a_valid[2][64];
    bit            a_dirty[2][64];
    bit [TAG-1:0]  a_tag[2][64];
    bit [BB-1:0]   a_data[2][64];
    bit            a_lru[64];
    logic [31:0]   cpu_wdata;
    logic          hit0, hit1;
    int            vic;
    logic [31:0]   rd_word;

    always_comb begin
        hit0 = a_valid[0][bus.c_index] && a_tag[0][bus.c_index] == bus.c_tag;
        hit1 = a_valid[1][bus.c_index] && a_tag[1][bus.c_index] == bus.c_tag;
        vic = !a_valid[0][bus.c_index] ? 0 :
              !a_valid[1][bus.c_index] ? 1 : int'(a_lru[bus.c_index]);
        bus.c_hit     = bus.c_enable && bus.c_cmp && (hit0 || hit1);
        bus.c_dirty   = a_valid[vic][bus.c_index] && a_dirty[vic][bus.c_index];
        bus.c_tag_out = a_tag[vic][bus.c_index];
        bus.c_data_wb = a_data[vic][bus.c_index];
        rd_word = a_data[hit1 ? 1 : 0][bus.c_index][int'(bus.c_word_sel)*32 +: 32];
    end

    always @(posedge clk) begin
        int w;
        w = hit1 ? 1 : 0;
        if (bus.c_enable && bus.c_cmp && bus.c_hit) begin
            if (bus.c_write) begin
                a_data[w][bus.c_index][int'(bus.c_word_sel)*32 +: 32] <= cpu_wdata;
                a_dirty[w][bus.c_index] <= 1'b1;
            end
            a_lru[bus.c_index] <= (w == 0);
        end else if (bus.c_enable && !bus.c_cmp && bus.c_write) begin
            a_valid[vic][bus.c_index] <= 1'b1;
            a_dirty[vic][bus.c_index] <= 1'b0;
            a_tag[vic][bus.c_index]   <= bus.c_tag;
            a_data[vic][bus.c_index]  <= bus.c_block_in;
            a_lru[bus.c_index]        <= (vic == 0);
        end
    end

    // behavioural memory with per-transaction latency
    bit [BB-1:0] mem_blk[int unsigned];
    bit [32:0]   mem_log[$];
    int          wait_cnt = 0;
    int          wb_lat = 0;
    int          al_lat = 0;
    bit          hold_ack = 1'b0;

    always_comb begin
        bus.mem_ack = bus.mem_req && !hold_ack &&
                      wait_cnt >= (bus.mem_we ? wb_lat : al_lat);
        bus.mem_rdata = mem_blk.exists(bus.mem_addr) ?
                        mem_blk[bus.mem_addr] : blk_init(bus.mem_addr);
    end

    always @(posedge clk) begin
        if (!bus.mem_req) wait_cnt <= 0;
        else if (bus.mem_ack) begin
            wait_cnt <= 0;
            mem_log.push_back({bus.mem_we, bus.mem_addr});
            if (bus.mem_we) mem_blk[bus.mem_addr] = bus.mem_wdata;
        end else wait_cnt <= wait_cnt + 1;
    end

    // reference model: resident tags per set (MRU first) and word memory
    bit [TAG-1:0] r_tag[64][$];
    bit           r_dirty[64][$];
    bit [31:0]    ref_mem[int unsigned];

    function automatic bit [31:0] ref_word(input bit [31:0] a);
        bit [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    task automatic do_req(input bit we, input bit [31:0] addr, input bit hold,
                          input int wbl, input int all);
        int idx, pos, cyc, held, bad_hold, exp_lat, expn;
        bit [TAG-1:0] t;
        bit exp_hit, exp_wb, got, d;
        bit [31:0] wba, ala, wd;
        idx = int'(addr[10:5]);
        t = addr[31:11];
        pos = -1;
        foreach (r_tag[idx][k]) if (r_tag[idx][k] == t) pos = k;
        exp_hit = (pos >= 0);
        exp_wb = 1'b0;
        wba = '0;
        if (!exp_hit && r_tag[idx].size() == 2 && r_dirty[idx][1]) begin
            exp_wb = 1'b1;
            wba = {r_tag[idx][1], addr[10:5], 5'b0};
        end
        ala = {addr[31:5], 5'b0};
        exp_lat = exp_hit ? 1 : 5 + all + (exp_wb ? wbl + 1 : 0);
        expn = exp_hit ? 0 : (exp_wb ? 2 : 1);
        wb_lat = wbl;
        al_lat = all;
        wd = $urandom;
        mem_log.delete();
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        cpu_wdata = wd;
        cyc = 0; got = 0; held = 0; bad_hold = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (hold && held < 20 && bus.mem_req && !bus.mem_we) begin
                hold_ack = 1'b1;
                held++;
                if (bus.cpu_ready || bus.c_enable) bad_hold++;
                if (held == 20) hold_ack = 1'b0;
            end
            if (bus.cpu_ready) got = 1'b1;
        end
        check("ready_seen", got, 1);
        if (hold) begin
            check("hold_req_cycles", held, 20);
            check("hold_quiet", bad_hold, 0);
        end else check("latency", cyc, exp_lat);
        if (!we && got) check("ld_data", rd_word, ref_word(addr));
        bus.cpu_req = 1'b0;
        check("mem_txn_cnt", mem_log.size(), expn);
        if (exp_wb && mem_log.size() >= 1)
            check("wb_addr", mem_log[0], {1'b1, wba});
        if (!exp_hit && mem_log.size() == expn)
            check("alloc_addr", mem_log[expn-1], {1'b0, ala});
        @(negedge clk);
        check("ready_pulse", bus.cpu_ready, 0);
        check("idle_mem_req", bus.mem_req, 0);
        if (we) ref_mem[{addr[31:2], 2'b00}] = wd;
        if (exp_hit) begin
            d = r_dirty[idx][pos] | we;
            r_tag[idx].delete(pos);
            r_dirty[idx].delete(pos);
        end else begin
            d = we;
            if (r_tag[idx].size() == 2) begin
                void'(r_tag[idx].pop_back());
                void'(r_dirty[idx].pop_back());
            end
        end
        r_tag[idx].push_front(t);
        r_dirty[idx].push_front(d);
    endtask

    task automatic reset_mid_wb(input bit we, input bit [31:0] addr);
        int cyc;
        wb_lat = 8;
        al_lat = 0;
        mem_log.delete();
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        cpu_wdata = $urandom;
        cyc = 0;
        while (!(bus.mem_req && bus.mem_we) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("wb_reached", bus.mem_req && bus.mem_we, 1);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ready", bus.cpu_ready, 0);
        check("rst_enable", bus.c_enable, 0);
        rst = 1'b1;
        check("rst_abandon", mem_log.size(), 0);
        do_req(we, addr, 0, 1, 2);
    endtask

    function automatic bit [31:0] rand_addr();
        return (32'($urandom_range(0, 3)) << 11) |
               (32'($urandom_range(0, 3)) << 5) |
               (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_c_enable", bus.c_enable, 0);
        check("rst_mem_req0", bus.mem_req, 0);
        check("rst_c_tag", bus.c_tag, 0);
        check("rst_c_index", bus.c_index, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b1;

        do_req(0, 32'h0000_0040, 0, 0, 1);
        do_req(0, 32'h0000_0044, 0, 0, 0);
`ifdef CACHE_PERF_CNT_EN
        check("perf_hit", perf_hit_cnt, 1);
        check("perf_miss", perf_miss_cnt, 1);
`endif
        do_req(1, 32'h0000_0048, 0, 0, 0);
        do_req(0, 32'h0000_1040, 0, 0, 2);
        do_req(0, 32'h0000_2040, 0, 1, 0);
        do_req(0, 32'h0000_3040, 1, 0, 0);
        do_req(1, 32'h0000_2044, 0, 0, 0);
        do_req(0, 32'h0000_3044, 0, 0, 0);
        reset_mid_wb(0, 32'h0000_4040);

        repeat (200)
            do_req(1'($urandom_range(0, 1)), rand_addr(), 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
